// File: rtl/accum_feeder.sv
// rtl/accum_feeder.sv - stimulus sequencer for the Accum accumulator with optional golden checker
// Define ACCUM_FEEDER_GOLD_EN to compile in the running-sum gold model and compare logic.
module accum_feeder #(
  parameter int WIDTH        = 32,
  parameter int DEPTH        = 256,
  parameter int RESET_CYCLES = 3,
  parameter int AW           = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic             hold,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [WIDTH-1:0] acc_out,
  output logic [WIDTH-1:0] acc_in,
  output logic             acc_en,
  output logic             acc_reset,
  output logic [AW-1:0]    index,
  output logic             busy,
  output logic             done,
  output logic [15:0]      mismatch_count,
  output logic             first_bad_valid,
  output logic [AW-1:0]    first_bad_index,
  output logic             pass
);

  localparam int CW = $clog2(RESET_CYCLES + 1);

  typedef enum logic [2:0] {S_IDLE, S_RST, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t           state, state_next;
  logic [CW-1:0]    rst_cnt;
  logic             start_ok;
  logic [WIDTH-1:0] mem [DEPTH];

  always_comb begin
    state_next = state;
    acc_in     = '0;
    acc_en     = 1'b0;
    acc_reset  = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    start_ok   = 1'b0;
    case (state)
      S_IDLE, S_DONE: begin
        done = (state == S_DONE);
        if (start) begin
          start_ok   = 1'b1;
          state_next = S_RST;
        end
      end
      S_RST: begin
        acc_reset = 1'b1;
        busy      = 1'b1;
        if (rst_cnt == CW'(1)) state_next = S_RUN;
      end
      S_RUN: begin
        busy   = 1'b1;
        acc_in = mem[index];
        acc_en = !hold;
        if (acc_en && index == AW'(DEPTH - 1)) state_next = S_DRAIN;
      end
      S_DRAIN: begin
        busy       = 1'b1;
        state_next = S_DONE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state   <= S_IDLE;
      rst_cnt <= '0;
      index   <= '0;
    end else begin
      state <= state_next;
      if (start_ok) begin
        rst_cnt <= CW'(RESET_CYCLES);
        index   <= '0;
      end else if (state == S_RST) begin
        rst_cnt <= rst_cnt - CW'(1);
      end
      // Wrap explicitly so non-power-of-two depths end the run back at 0.
      if (acc_en) index <= (index == AW'(DEPTH - 1)) ? '0 : index + AW'(1);
    end
  end

  // Stimulus memory has no reset; writes are locked out for the whole run.
  always_ff @(posedge clock) begin
    if (wr_en && !busy) mem[wr_addr] <= wr_data;
  end

`ifdef ACCUM_FEEDER_GOLD_EN
  logic [WIDTH-1:0] gold;
  logic             chk;
  logic [AW-1:0]    chk_idx;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      gold            <= '0;
      chk             <= 1'b0;
      chk_idx         <= '0;
      mismatch_count  <= '0;
      first_bad_valid <= 1'b0;
      first_bad_index <= '0;
    end else begin
      chk <= acc_en;
      if (acc_en) begin
        gold    <= gold + acc_in;
        chk_idx <= index;
      end
      if (start_ok) begin
        gold            <= '0;
        mismatch_count  <= '0;
        first_bad_valid <= 1'b0;
        first_bad_index <= '0;
      end else if (chk && acc_out != gold) begin
        if (mismatch_count != 16'hFFFF) mismatch_count <= mismatch_count + 16'd1;
        if (!first_bad_valid) begin
          first_bad_valid <= 1'b1;
          first_bad_index <= chk_idx;
        end
      end
    end
  end
`else
  logic unused_acc_out;
  assign unused_acc_out  = ^acc_out;
  assign mismatch_count  = '0;
  assign first_bad_valid = 1'b0;
  assign first_bad_index = '0;
`endif

  assign pass = done && (mismatch_count == 16'd0);

endmodule
